snd_scheduler: RTL and testbench
================================

SND_SCHEDULER -- requirements
Module: snd_scheduler

Interface
REQ-001 SHALL have parameter N_SND, default 6, meaning number of sound IDs: 0 tictac, 1 explosion, 2 pick_item, 3 ouch, 4 cri, 5 heart_beat.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning sample ROM address width.
REQ-003 SHALL have port clk_50, input, 1 bit: the only clock; all logic on posedge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, N_SND bits: one-cycle request pulse per sound ID; multiple bits may be high at once.
REQ-006 SHALL have port play_ready, input, 1 bit: the sample player is idle.
REQ-007 SHALL have port play_done, input, 1 bit: one-cycle pulse when the player has reached its end address.
REQ-008 SHALL have port play_start, output, 1 bit: one-cycle pulse that launches the player.
REQ-009 SHALL have ports play_start_addr and play_end_addr, outputs, ADDR_W bits each: the address range of the granted sound; held stable from play_start until the next play_start.
REQ-010 SHALL have port play_id, output, 3 bits: ID of the granted or playing sound.
REQ-011 SHALL have port play_abort, output, 1 bit: one-cycle pulse that stops the player (PREEMPT_EN only).
REQ-012 SHALL have port pending, output, N_SND bits: registered queue of requested, not-yet-granted sounds.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 SHALL have port merge_cnt, output, 8 bits: saturating count of requests coalesced into an already-pending bit.

Function
REQ-015 SHALL set pending[i] on the clock edge after req[i]=1; pending[i] already 1 -> merge_cnt+1, saturating at 255.
REQ-016 SHALL clear pending[i] on the grant edge; a simultaneous req[i] on that edge SHALL leave pending[i]=1 and SHALL NOT count as a merge.
REQ-017 SHALL implement FSM states IDLE, PLAY and ABORT (ABORT only exists with PREEMPT_EN).
REQ-018 IDLE: when pending!=0 and play_ready=1, SHALL grant the highest-priority pending ID and pulse play_start for 1 cycle, with addresses and play_id valid in that same cycle, then go to PLAY.
REQ-019 SHALL use fixed priority, highest first: explosion, cri, ouch, pick_item, heart_beat, tictac.
REQ-020 SHALL have latency req pulse at edge n -> play_start high after edge n+1 (2 clocks) when idle and play_ready=1.
REQ-021 PLAY: play_done=1 -> IDLE; the next grant can occur on the following edge.
REQ-022 SHALL ignore play_done outside PLAY.
REQ-023 SHALL hold play_start in IDLE while play_ready=0, with pending still accumulating.
REQ-024 A request for the sound currently playing SHALL set its pending bit, so the sound replays after the current one.

Reset
REQ-025 SHALL, while reset_n=0: state=IDLE; pending=0; merge_cnt=0; play_start=0; play_abort=0; play_id=0; play_start_addr=0; play_end_addr=0; busy=0.
REQ-026 Reset asserted mid-PLAY SHALL discard queue and grant immediately, with no play_abort pulse; after release, SHALL wait in IDLE for play_ready.

Configuration
REQ-027 With SND_PREEMPT_EN defined: in PLAY, a pending ID of strictly higher priority than play_id SHALL pulse play_abort for 1 cycle and go to ABORT; ABORT -> IDLE when play_ready=1; the aborted sound is not requeued.
REQ-028 With SND_PREEMPT_EN defined: equal or lower priority SHALL never preempt.
REQ-029 Without SND_PREEMPT_EN: play_abort SHALL be constant 0, no ABORT state SHALL exist, and every sound plays to play_done.

Structure
REQ-030 Package snd_pkg SHALL hold: sound ID enum; start/end address constants (tictac 0..3846, explosion 3847..11964, pick_item 11965..14365, ouch 14366..17886, cri 17887..21407, heart_beat shares pick_item range); priority order table; FSM state typedef.
REQ-031 Sub-module snd_prio_enc (combinational, pending -> winner ID + valid, ordered by the package table) SHALL be instantiated once for grant and reused for the preemption compare.

Verification
REQ-032 Bench SHALL cover: req[1] pulse, idle, play_ready=1 -> play_start 2 clocks later, addresses 3847/11964, play_id=1.
REQ-033 Bench SHALL cover: req=6'b100001 same cycle -> tictac and heart_beat granted in order heart_beat then tictac, each after its play_done.
REQ-034 Bench SHALL cover: req[0] pulsed 3 times while tictac pending and not granted -> merge_cnt=2, a single tictac play.
REQ-035 Bench SHALL cover: in PLAY on tictac, req[1] -> with SND_PREEMPT_EN: play_abort 1 cycle later, explosion starts after play_ready; without it: explosion starts only after play_done.
REQ-036 Bench SHALL cover: reset_n low mid-PLAY with pending=6'h3F -> all outputs 0, no play_start until play_ready and a new req.
REQ-037 Bench SHALL cover: 300 merged requests -> merge_cnt holds at 255.

Source files
------------

// File: rtl/snd_pkg.sv
// Shared sound IDs, sample ROM ranges, priority table and scheduler state encoding.
package snd_pkg;

  typedef enum logic [2:0] {
    SndTictac    = 3'd0,
    SndExplosion = 3'd1,
    SndPickItem  = 3'd2,
    SndOuch      = 3'd3,
    SndCri       = 3'd4,
    SndHeartBeat = 3'd5
  } snd_id_e;

  localparam int unsigned NumSnd = 6;

  localparam logic [15:0] TictacStart    = 16'd0;
  localparam logic [15:0] TictacEnd      = 16'd3846;
  localparam logic [15:0] ExplosionStart = 16'd3847;
  localparam logic [15:0] ExplosionEnd   = 16'd11964;
  localparam logic [15:0] PickItemStart  = 16'd11965;
  localparam logic [15:0] PickItemEnd    = 16'd14365;
  localparam logic [15:0] OuchStart      = 16'd14366;
  localparam logic [15:0] OuchEnd        = 16'd17886;
  localparam logic [15:0] CriStart       = 16'd17887;
  localparam logic [15:0] CriEnd         = 16'd21407;

  // Index 0 is the highest priority.
  localparam snd_id_e PrioOrder [NumSnd] = '{
    SndExplosion, SndCri, SndOuch, SndPickItem, SndHeartBeat, SndTictac
  };

  typedef logic [1:0] sched_state_t;
  localparam sched_state_t StIdle  = 2'd0;
  localparam sched_state_t StPlay  = 2'd1;
  localparam sched_state_t StAbort = 2'd2;

  function automatic logic [2:0] prio_rank(logic [2:0] id);
    logic [2:0] rank;
    rank = 3'(NumSnd - 1);
    for (int r = 0; r < NumSnd; r++) begin
      if (PrioOrder[r] == id) rank = 3'(r);
    end
    return rank;
  endfunction

  function automatic logic [15:0] snd_start_addr(logic [2:0] id);
    case (id)
      SndExplosion:             return ExplosionStart;
      SndPickItem, SndHeartBeat: return PickItemStart;
      SndOuch:                  return OuchStart;
      SndCri:                   return CriStart;
      default:                  return TictacStart;
    endcase
  endfunction

  function automatic logic [15:0] snd_end_addr(logic [2:0] id);
    case (id)
      SndExplosion:             return ExplosionEnd;
      SndPickItem, SndHeartBeat: return PickItemEnd;
      SndOuch:                  return OuchEnd;
      SndCri:                   return CriEnd;
      default:                  return TictacEnd;
    endcase
  endfunction

endpackage

// File: rtl/snd_prio_enc.sv
// Fixed-priority encoder: picks the highest-priority set bit of pending using the package table.
module snd_prio_enc
  import snd_pkg::*;
#(
  parameter int unsigned N_SND = 6
) (
  input  logic [N_SND-1:0] pending,
  output logic [2:0]       win_id,
  output logic             valid
);

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    win_id = 3'd0;
    valid  = 1'b0;
    for (int r = NumSnd - 1; r >= 0; r--) begin
      if (int'(PrioOrder[r]) < int'(N_SND) && pending[PrioOrder[r]]) begin
        win_id = PrioOrder[r];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snd_scheduler.sv
// Sound request scheduler: queues requests and launches the sample player by priority.
// Optional preemption of a lower-priority sound is enabled with `define SND_PREEMPT_EN.
module snd_scheduler
  import snd_pkg::*;
#(
  parameter int unsigned N_SND  = 6,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic [N_SND-1:0]  req,
  input  logic              play_ready,
  input  logic              play_done,
  output logic              play_start,
  output logic [ADDR_W-1:0] play_start_addr,
  output logic [ADDR_W-1:0] play_end_addr,
  output logic [2:0]        play_id,
  output logic              play_abort,
  output logic [N_SND-1:0]  pending,
  output logic              busy,
  output logic [7:0]        merge_cnt
);

  sched_state_t      state_q, state_d;
  logic [N_SND-1:0]  pending_q, pending_d, grant_mask, merges;
  logic [7:0]        merge_cnt_q, merge_cnt_d;
  logic [3:0]        merge_add;
  logic [8:0]        merge_sum;
  logic              play_start_q;
  logic [2:0]        play_id_q;
  logic [ADDR_W-1:0] start_addr_q, end_addr_q;
  logic [2:0]        win_id;
  logic              win_valid;
  logic              grant;
  logic              preempt;

  snd_prio_enc #(
    .N_SND(N_SND)
  ) u_prio_enc (
    .pending(pending_q),
    .win_id (win_id),
    .valid  (win_valid)
  );

  assign grant      = (state_q == StIdle) && win_valid && play_ready;
  assign grant_mask = grant ? (N_SND'(1) << win_id) : '0;

`ifdef SND_PREEMPT_EN
  assign preempt = (state_q == StPlay) && !play_done && win_valid &&
                   (prio_rank(win_id) < prio_rank(play_id_q));
`else
  assign preempt = 1'b0;
`endif

  // A request landing on the grant edge re-arms the bit and is not a merge.
  assign merges    = req & pending_q & ~grant_mask;
  assign pending_d = (pending_q & ~grant_mask) | req;

  always_comb begin
    merge_add = 4'd0;
    for (int i = 0; i < int'(N_SND); i++) begin
      merge_add = merge_add + 4'(merges[i]);
    end
    merge_sum   = 9'(merge_cnt_q) + 9'(merge_add);
    merge_cnt_d = (merge_sum > 9'd255) ? 8'hFF : merge_sum[7:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (grant) state_d = StPlay;
      StPlay: begin
        if (play_done)    state_d = StIdle;
        else if (preempt) state_d = StAbort;
      end
`ifdef SND_PREEMPT_EN
      StAbort: if (play_ready) state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      merge_cnt_q  <= 8'd0;
      play_start_q <= 1'b0;
      play_id_q    <= 3'd0;
      start_addr_q <= '0;
      end_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      merge_cnt_q  <= merge_cnt_d;
      play_start_q <= grant;
      if (grant) begin
        play_id_q    <= win_id;
        start_addr_q <= ADDR_W'(snd_start_addr(win_id));
        end_addr_q   <= ADDR_W'(snd_end_addr(win_id));
      end
    end
  end

`ifdef SND_PREEMPT_EN
  logic play_abort_q;
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) play_abort_q <= 1'b0;
    else          play_abort_q <= preempt;
  end
  assign play_abort = play_abort_q;
`else
  assign play_abort = 1'b0;
`endif

  assign play_start      = play_start_q;
  assign play_start_addr = start_addr_q;
  assign play_end_addr   = end_addr_q;
  assign play_id         = play_id_q;
  assign pending         = pending_q;
  assign busy            = (state_q != StIdle);
  assign merge_cnt       = merge_cnt_q;

endmodule

// File: tb/tb_snd_scheduler.sv
// Directed self-checking bench for snd_scheduler; honours SND_PREEMPT_EN when defined.
module tb_snd_scheduler;

  logic        clk_50 = 1'b0;
  logic        reset_n;
  logic [5:0]  req;
  logic        play_ready;
  logic        play_done;
  logic        play_start;
  logic [15:0] play_start_addr;
  logic [15:0] play_end_addr;
  logic [2:0]  play_id;
  logic        play_abort;
  logic [5:0]  pending;
  logic        busy;
  logic [7:0]  merge_cnt;

  int vectors = 0;
  int errors  = 0;

  always #10 clk_50 = ~clk_50;

  snd_scheduler #(
    .N_SND (6),
    .ADDR_W(16)
  ) dut (
    .clk_50         (clk_50),
    .reset_n        (reset_n),
    .req            (req),
    .play_ready     (play_ready),
    .play_done      (play_done),
    .play_start     (play_start),
    .play_start_addr(play_start_addr),
    .play_end_addr  (play_end_addr),
    .play_id        (play_id),
    .play_abort     (play_abort),
    .pending        (pending),
    .busy           (busy),
    .merge_cnt      (merge_cnt)
  );

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".start"}, 32'(play_start), 32'd0);
    chk({tag, ".abort"}, 32'(play_abort), 32'd0);
    chk({tag, ".busy"},  32'(busy), 32'd0);
  endtask

  task automatic done_pulse();
    play_done = 1'b1;
    tick();
    play_done = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    req        = 6'd0;
    play_ready = 1'b0;
    play_done  = 1'b0;
    tick();
    tick();
    // Reset state
    chk_idle_outputs("rst");
    chk("rst.pending", 32'(pending), 32'd0);
    chk("rst.merge",   32'(merge_cnt), 32'd0);
    chk("rst.id",      32'(play_id), 32'd0);
    chk("rst.saddr",   32'(play_start_addr), 32'd0);
    chk("rst.eaddr",   32'(play_end_addr), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single explosion request, two-clock latency
    play_ready = 1'b1;
    req = 6'b000010;
    tick();
    req = 6'd0;
    chk("exp.pending", 32'(pending), 32'h02);
    chk("exp.nostart", 32'(play_start), 32'd0);
    tick();
    chk("exp.start", 32'(play_start), 32'd1);
    chk("exp.saddr", 32'(play_start_addr), 32'd3847);
    chk("exp.eaddr", 32'(play_end_addr), 32'd11964);
    chk("exp.id",    32'(play_id), 32'd1);
    chk("exp.busy",  32'(busy), 32'd1);
    chk("exp.clr",   32'(pending), 32'd0);
    tick();
    chk("exp.pulse", 32'(play_start), 32'd0);
    chk("exp.play",  32'(busy), 32'd1);
    done_pulse();
    chk("exp.idle", 32'(busy), 32'd0);

    // Tictac and heart_beat together: heart_beat first
    req = 6'b100001;
    tick();
    req = 6'd0;
    chk("dual.pending", 32'(pending), 32'h21);
    tick();
    chk("dual.start1", 32'(play_start), 32'd1);
    chk("dual.id1",    32'(play_id), 32'd5);
    chk("dual.saddr1", 32'(play_start_addr), 32'd11965);
    chk("dual.eaddr1", 32'(play_end_addr), 32'd14365);
    chk("dual.pend1",  32'(pending), 32'h01);
    tick();
    tick();
    chk("dual.wait", 32'(play_start), 32'd0);
    done_pulse();
    chk("dual.idle", 32'(busy), 32'd0);
    tick();
    chk("dual.start2", 32'(play_start), 32'd1);
    chk("dual.id2",    32'(play_id), 32'd0);
    chk("dual.saddr2", 32'(play_start_addr), 32'd0);
    chk("dual.eaddr2", 32'(play_end_addr), 32'd3846);
    done_pulse();

    // Three tictac requests while player not ready: two merges, one play
    play_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req = 6'b000001;
      tick();
      req = 6'd0;
      tick();
    end
    chk("merge.cnt",  32'(merge_cnt), 32'd2);
    chk("merge.pend", 32'(pending), 32'h01);
    chk_idle_outputs("merge.hold");
    play_ready = 1'b1;
    tick();
    chk("merge.start", 32'(play_start), 32'd1);
    chk("merge.id",    32'(play_id), 32'd0);
    done_pulse();
    tick();
    chk_idle_outputs("merge.single");

    // Explosion requested while tictac plays
    req = 6'b000001;
    tick();
    req = 6'd0;
    tick();
    chk("pre.start", 32'(play_start), 32'd1);
    chk("pre.id",    32'(play_id), 32'd0);
    tick();
    play_ready = 1'b0;
    req = 6'b000010;
    tick();
    req = 6'd0;
    chk("pre.pend",   32'(pending), 32'h02);
    chk("pre.abort0", 32'(play_abort), 32'd0);
    tick();
`ifdef SND_PREEMPT_EN
    chk("pre.abort1", 32'(play_abort), 32'd1);
    tick();
    chk("pre.abort2", 32'(play_abort), 32'd0);
    chk("pre.hold",   32'(busy), 32'd1);
    chk("pre.nostart", 32'(play_start), 32'd0);
    play_ready = 1'b1;
    tick();
    chk("pre.idle", 32'(busy), 32'd0);
    tick();
`else
    chk("pre.noabort", 32'(play_abort), 32'd0);
    tick();
    chk("pre.nostart", 32'(play_start), 32'd0);
    chk("pre.stillplay", 32'(play_id), 32'd0);
    play_ready = 1'b1;
    done_pulse();
    chk("pre.idle", 32'(busy), 32'd0);
    tick();
`endif
    chk("pre.start2", 32'(play_start), 32'd1);
    chk("pre.id2",    32'(play_id), 32'd1);
    done_pulse();

    // Reset mid-play with full queue
    req = 6'h3F;
    tick();
    req = 6'd0;
    tick();
    chk("rstp.id", 32'(play_id), 32'd1);
    req = 6'h3F;
    tick();
    req = 6'd0;
    chk("rstp.pend",  32'(pending), 32'h3F);
    chk("rstp.busy",  32'(busy), 32'd1);
    chk("rstp.merge", 32'(merge_cnt), 32'd7);
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("rstp.async");
    chk("rstp.pend0",  32'(pending), 32'd0);
    chk("rstp.merge0", 32'(merge_cnt), 32'd0);
    chk("rstp.id0",    32'(play_id), 32'd0);
    chk("rstp.saddr0", 32'(play_start_addr), 32'd0);
    chk("rstp.eaddr0", 32'(play_end_addr), 32'd0);
    play_ready = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    play_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_idle_outputs("rstp.quiet");
    end
    req = 6'b000001;
    tick();
    req = 6'd0;
    tick();
    chk("rstp.start", 32'(play_start), 32'd1);
    chk("rstp.id",    32'(play_id), 32'd0);
    done_pulse();

    // Saturation of merge_cnt
    play_ready = 1'b0;
    for (int k = 0; k < 300; k++) begin
      req = 6'b000001;
      tick();
      if (k == 255) chk("sat.mid", 32'(merge_cnt), 32'd255);
    end
    req = 6'd0;
    chk("sat.cnt", 32'(merge_cnt), 32'd255);
    tick();
    chk("sat.hold", 32'(merge_cnt), 32'd255);
    chk("sat.pend", 32'(pending), 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
